regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the 32 x 32-bit register file's single write port (`A3`/`WD3`/`WE3`). It shares that port between two requesters: the ALU result path (requester 0) and the load/memory result path (requester 1). It uses round-robin arbitration with valid/ready handshakes, a global hold, x0 write suppression and a one-cycle registered output stage. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: register address/data widths, the x0 address, requester
// indices used to address grant/valid vectors, and a saturating
// increment helper for the conflict counter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Requester indices into req/grant vectors; also the value stored in
  // the round-robin pointer when that requester wins.
  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter producing a one-hot (or zero) grant.
// Latency: purely combinational, zero cycles.
// Backpressure: hold forces grant to zero; losers simply see no grant.
//
// Ports:
//   req   [1:0] request vector, indexed by WB_ALU / WB_MEM
//   hold        suppresses every grant while high
//   ptr         index of the requester that won the last transfer
//   grant [1:0] one-hot grant, all-zero when nothing is granted
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       hold,
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (!hold) begin
      if (req[WB_ALU] && req[WB_MEM]) begin
        // Contention: the requester that did not win last goes next.
        if (ptr) begin
          grant[WB_ALU] = 1'b1;
        end else begin
          grant[WB_MEM] = 1'b1;
        end
      end else if (req[WB_ALU]) begin
        grant[WB_ALU] = 1'b1;
      end else if (req[WB_MEM]) begin
        grant[WB_MEM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load paths.
// Latency: one cycle from acceptance to A3/WD3/WE3.
// Backpressure: only arbitration and hold deassert ready; the output stage never stalls.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   hold                     pipeline hold, blocks all grants combinationally
//   alu_valid/addr/data      requester 0 (ALU result), alu_ready = accepted
//   mem_valid/addr/data      requester 1 (load result), mem_ready = accepted
//   A3/WD3/WE3               registered register-file write port
//   last_grant               round-robin pointer (0 = ALU won last, 1 = memory)
//   conflict_cnt             saturating count of un-held cycles with both valid
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]        req;
  logic [1:0]        grant;

  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              we3_q, we3_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign req[WB_ALU] = alu_valid;
  assign req[WB_MEM] = mem_valid;

  rr_arb2 u_arb (
    .hold  (hold),
    .req   (req),
    .ptr   (last_grant_q),
    .grant (grant)
  );

  assign alu_ready = grant[WB_ALU];
  assign mem_ready = grant[WB_MEM];

  // Grant is one-hot, so a two-way mux keyed on the memory grant suffices.
  assign win_addr = grant[WB_MEM] ? mem_addr : alu_addr;
  assign win_data = grant[WB_MEM] ? mem_data : alu_data;

  always_comb begin
    a3_d           = a3_q;
    wd3_d          = wd3_q;
    we3_d          = 1'b0;
    last_grant_d   = last_grant_q;
    conflict_cnt_d = conflict_cnt_q;

    if (|grant) begin
      a3_d         = win_addr;
      wd3_d        = win_data;
      // x0 writes are consumed here but never reach the register file.
      we3_d        = (win_addr != ADDR_W'(REG_ZERO));
      last_grant_d = grant[WB_MEM];
    end

    if (alu_valid && mem_valid && !hold) begin
      conflict_cnt_d = sat_inc(conflict_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a3_q           <= '0;
      wd3_q          <= '0;
      we3_q          <= 1'b0;
      // Pointer starts at "memory won last" so the first conflict goes to the ALU.
      last_grant_q   <= 1'b1;
      conflict_cnt_q <= '0;
    end else begin
      a3_q           <= a3_d;
      wd3_q          <= wd3_d;
      we3_q          <= we3_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign A3           = a3_q;
  assign WD3          = wd3_q;
  assign WE3          = we3_q;
  assign last_grant   = last_grant_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus a
// scoreboard of expected write-port values, and hand-written sequences
// for asynchronous reset and counter saturation.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic        last_grant;
  logic [15:0] conflict_cnt;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .A3           (A3),
    .WD3          (WD3),
    .WE3          (WE3),
    .last_grant   (last_grant),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        er_a;
    logic        er_m;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  vec_t tbl[$];
  wb_t  sb[$];

  int checks = 0;
  int failures = 0;

  // Reference state, advanced from the hand-written expected grants.
  logic        m_last;
  int          m_cnt;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;

  function automatic vec_t mk(input logic h, input logic av, input logic [4:0] aa,
                              input logic [31:0] ad, input logic mv, input logic [4:0] ma,
                              input logic [31:0] md, input logic era, input logic erm);
    vec_t v;
    v.hold = h; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md; v.er_a = era; v.er_m = erm;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_cnt  = 0;
    m_a3   = '0;
    m_wd3  = '0;
    sb.delete();
  endtask

  // Drives one vector for one cycle; called just after a rising edge.
  task automatic apply(input vec_t v, input string tag);
    wb_t e;
    wb_t got;
    hold      = v.hold;
    alu_valid = v.av;
    alu_addr  = v.aa;
    alu_data  = v.ad;
    mem_valid = v.mv;
    mem_addr  = v.ma;
    mem_data  = v.md;
    @(negedge clk);
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(v.er_a));
    check({tag, ".mem_ready"}, 64'(mem_ready), 64'(v.er_m));

    if (!v.hold && v.av && v.mv && m_cnt < 65535) m_cnt++;
    if (v.er_a) begin
      m_a3 = v.aa; m_wd3 = v.ad; m_last = 1'b0;
      e.we = (v.aa != 5'd0);
    end else if (v.er_m) begin
      m_a3 = v.ma; m_wd3 = v.md; m_last = 1'b1;
      e.we = (v.ma != 5'd0);
    end else begin
      e.we = 1'b0;
    end
    e.a = m_a3;
    e.d = m_wd3;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
    end else begin
      got = sb.pop_front();
      check({tag, ".WE3"}, 64'(WE3), 64'(got.we));
      check({tag, ".A3"},  64'(A3),  64'(got.a));
      check({tag, ".WD3"}, 64'(WD3), 64'(got.d));
    end
    check({tag, ".last_grant"},   64'(last_grant),   64'(m_last));
    check({tag, ".conflict_cnt"}, 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    // ALU addr 6 / data 40, memory addr 7 / data 77, re-presented each cycle.
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 1, 0)); // ALU wins first conflict
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 1));
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 1, 0));
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 1)); // count reaches 4
    tbl.push_back(mk(0, 1, 5'd9, 32'h20, 0, 5'd0, 32'h0,  1, 0)); // single ALU request
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0)); // idle: WE3 drops
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd0, 32'hDEAD, 0, 1)); // x0 write
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,  1, 5'd12, 32'h1234, 0, 1)); // single memory
    tbl.push_back(mk(0, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0,  1, 0)); // accepted just before hold
    tbl.push_back(mk(1, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 0));
    tbl.push_back(mk(1, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 0));
    tbl.push_back(mk(1, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 0));
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 0, 1)); // ALU won last -> memory
    tbl.push_back(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 1, 0));
    tbl.push_back(mk(1, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0,  0, 0)); // hold blocks single request
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 0));

    // Power-on reset.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.WE3", 64'(WE3), 64'd0);
    check("reset.A3", 64'(A3), 64'd0);
    check("reset.WD3", 64'(WD3), 64'd0);
    check("reset.last_grant", 64'(last_grant), 64'd1);
    check("reset.conflict_cnt", 64'(conflict_cnt), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset arriving mid-stream, with a write in the output stage.
    apply(mk(0, 1, 5'd5, 32'h55, 1, 5'd8, 32'h88, 0, 1), "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.WE3", 64'(WE3), 64'd0);
    check("async_rst.A3", 64'(A3), 64'd0);
    check("async_rst.WD3", 64'(WD3), 64'd0);
    check("async_rst.conflict_cnt", 64'(conflict_cnt), 64'd0);
    check("async_rst.last_grant", 64'(last_grant), 64'd1);
    // A request presented across an edge while reset is high leaves no trace.
    @(posedge clk);
    #1;
    check("rst_discard.WE3", 64'(WE3), 64'd0);
    check("rst_discard.A3", 64'(A3), 64'd0);
    rst = 1'b0;
    model_reset();
    apply(mk(0, 1, 5'd6, 32'h40, 1, 5'd7, 32'h77, 1, 0), "post_rst_conflict");

    // Counter saturation: 65537 back-to-back conflicts from a fresh reset.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    hold = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h40;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
    repeat (65537) @(posedge clk);
    #1;
    check("sat.conflict_cnt", 64'(conflict_cnt), 64'hFFFF);
    // Odd number of alternating grants starting with ALU: ALU won last.
    check("sat.last_grant", 64'(last_grant), 64'd0);
    check("sat.A3", 64'(A3), 64'd6);
    @(posedge clk);
    #1;
    check("sat_hold.conflict_cnt", 64'(conflict_cnt), 64'hFFFF);
    check("sat_hold.A3", 64'(A3), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
